// File: rtl/landing_decoder.sv
// Landing-light receive decoder: classifies consecutive lamp patterns into wind modes and locks on agreement.
// Optional saturating error counter enabled by defining LANDING_DECODER_ERR_COUNT_EN.
module landing_decoder #(
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [2:0] pattern,
    output logic [1:0] mode,
    output logic       locked,
    output logic       mode_change,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [2:0] CODE_C = 3'b101;
    localparam logic [2:0] CODE_A = 3'b010;
    localparam logic [2:0] CODE_L = 3'b100;
    localparam logic [2:0] CODE_R = 3'b001;

    localparam logic [1:0] CLS_CALM  = 2'b00;
    localparam logic [1:0] CLS_WIND0 = 2'b01;
    localparam logic [1:0] CLS_WIND1 = 2'b10;
    localparam logic [1:0] CLS_BAD   = 2'b11;

    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRACK  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t           state;
    logic [2:0]       prev_code;
    logic [1:0]       cand;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       cls;
    logic [1:0]       cand_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_set;

    function automatic logic code_legal(input logic [2:0] p);
        return (p == CODE_C) || (p == CODE_A) || (p == CODE_L) || (p == CODE_R);
    endfunction

    function automatic logic [1:0] classify(input logic [2:0] p, input logic [2:0] c);
        logic [1:0] r;
        case ({p, c})
            {CODE_C, CODE_A}, {CODE_A, CODE_C},
            {CODE_L, CODE_C}, {CODE_R, CODE_C}: r = CLS_CALM;
            {CODE_L, CODE_R}, {CODE_R, CODE_A},
            {CODE_A, CODE_L}, {CODE_C, CODE_L}: r = CLS_WIND0;
            {CODE_R, CODE_L}, {CODE_L, CODE_A},
            {CODE_A, CODE_R}, {CODE_C, CODE_R}: r = CLS_WIND1;
            default:                            r = CLS_BAD;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= LOCK_CNT) ? LOCK_CNT : c + CNT_W'(1);
    endfunction

    // Agreement counting: a new class restarts the run at one.
    always_comb begin
        cls      = classify(prev_code, pattern);
        cand_nxt = cand;
        cnt_nxt  = sat_inc(cnt);
        if (cls != cand) begin
            cand_nxt = cls;
            cnt_nxt  = CNT_W'(1);
        end
        err_set = 1'b0;
        if (valid) begin
            case (state)
                IDLE:          err_set = !code_legal(pattern);
                TRACK, LOCKED: err_set = (cls == CLS_BAD);
                default:       err_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prev_code   <= 3'b000;
            cand        <= CLS_CALM;
            cnt         <= '0;
            mode        <= CLS_CALM;
            locked      <= 1'b0;
            mode_change <= 1'b0;
            err         <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            err         <= err_set;
            if (valid) begin
                case (state)
                    IDLE: begin
                        if (code_legal(pattern)) begin
                            prev_code <= pattern;
                            state     <= TRACK;
                        end
                    end
                    TRACK, LOCKED: begin
                        if (err_set) begin
                            locked <= 1'b0;
                            cnt    <= '0;
                            if (code_legal(pattern)) begin
                                prev_code <= pattern;
                                state     <= TRACK;
                            end else begin
                                state     <= IDLE;
                            end
                        end else begin
                            prev_code <= pattern;
                            cand      <= cand_nxt;
                            cnt       <= cnt_nxt;
                            if (state == TRACK) begin
                                if (cnt_nxt == LOCK_CNT) begin
                                    locked      <= 1'b1;
                                    mode        <= cand_nxt;
                                    mode_change <= 1'b1;
                                    state       <= LOCKED;
                                end
                            end else if (cnt_nxt == LOCK_CNT && cand_nxt != mode) begin
                                mode        <= cand_nxt;
                                mode_change <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LANDING_DECODER_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (err_set && err_count != 8'd255) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_landing_decoder.sv
// Self-checking bench for landing_decoder: directed test-plan steps followed by randomized traffic
// compared every cycle against a behavioural model of the lamp-transition rules.
module tb_landing_decoder;

    localparam int LOCK = 3;
`ifdef LANDING_DECODER_ERR_COUNT_EN
    localparam int ECNT_EN = 1;
`else
    localparam int ECNT_EN = 0;
`endif

    localparam logic [2:0] C = 3'b101;
    localparam logic [2:0] A = 3'b010;
    localparam logic [2:0] L = 3'b100;
    localparam logic [2:0] R = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [2:0] pattern;
    logic [1:0] mode,  mode1;
    logic       locked, locked1;
    logic       mode_change, mode_change1;
    logic       err, err1;
    logic [7:0] err_count, err_count1;

    landing_decoder #(.LOCK_COUNT(LOCK), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .pattern(pattern),
        .mode(mode), .locked(locked), .mode_change(mode_change),
        .err(err), .err_count(err_count)
    );

    landing_decoder #(.LOCK_COUNT(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .valid(valid), .pattern(pattern),
        .mode(mode1), .locked(locked1), .mode_change(mode_change1),
        .err(err1), .err_count(err_count1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit         m_have;
    logic [2:0] m_prev;
    int         m_run, m_cand, m_mode, m_errcnt;
    bit         m_locked, m_mc, m_err;

    function automatic bit is_legal(input logic [2:0] p);
        return p == C || p == A || p == L || p == R;
    endfunction

    // Position on the L -> R -> A -> L wheel; WIND0 steps forward, WIND1 steps backward.
    function automatic int wheel(input logic [2:0] p);
        if (p == L) return 0;
        if (p == R) return 1;
        return 2;
    endfunction

    function automatic int cls_of(input logic [2:0] p, input logic [2:0] c);
        int i, j;
        if (!is_legal(p) || !is_legal(c)) return -1;
        if (p == C) begin
            if (c == A) return 0;
            if (c == L) return 1;
            if (c == R) return 2;
            return -1;
        end
        if (c == C) return 0;
        i = wheel(p);
        j = wheel(c);
        if (j == (i + 1) % 3) return 1;
        if (j == (i + 2) % 3) return 2;
        return -1;
    endfunction

    function automatic logic [2:0] follow(input bit have, input logic [2:0] p, input int cls);
        if (!have) return C;
        if (cls == 0) return (p == C) ? A : C;
        if (p == C) return (cls == 1) ? L : R;
        if (cls == 1) return (p == L) ? R : (p == R) ? A : L;
        return (p == R) ? L : (p == L) ? A : R;
    endfunction

    task automatic model_reset();
        m_have = 0; m_prev = 3'b000; m_run = 0; m_cand = 0;
        m_mode = 0; m_locked = 0; m_mc = 0; m_err = 0; m_errcnt = 0;
    endtask

    task automatic model_update(input bit r, input bit v, input logic [2:0] p);
        int c;
        m_mc = 0;
        m_err = 0;
        if (r) begin
            model_reset();
            return;
        end
        if (!v) return;
        if (!m_have) begin
            if (is_legal(p)) begin
                m_have = 1;
                m_prev = p;
            end else begin
                m_err = 1;
            end
        end else begin
            c = cls_of(m_prev, p);
            if (c < 0) begin
                m_err = 1;
                m_locked = 0;
                m_run = 0;
                if (is_legal(p)) m_prev = p;
                else m_have = 0;
            end else begin
                if (c == m_cand) m_run++;
                else begin
                    m_cand = c;
                    m_run = 1;
                end
                m_prev = p;
                if (!m_locked && m_run >= LOCK) begin
                    m_locked = 1;
                    m_mode = m_cand;
                    m_mc = 1;
                end else if (m_locked && m_run >= LOCK && m_cand != m_mode) begin
                    m_mode = m_cand;
                    m_mc = 1;
                end
            end
        end
        if (m_err && ECNT_EN != 0 && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input bit r, input bit v, input logic [2:0] p);
        reset = r;
        valid = v;
        pattern = p;
        @(posedge clk);
        model_update(r, v, p);
        #1;
        chk("model mode", 32'(mode), 32'(m_mode));
        chk("model locked", 32'(locked), 32'(m_locked));
        chk("model mode_change", 32'(mode_change), 32'(m_mc));
        chk("model err", 32'(err), 32'(m_err));
        chk("model err_count", 32'(err_count), 32'(m_errcnt));
    endtask

    task automatic feed(input logic [2:0] p);
        step(0, 1, p);
    endtask

    task automatic do_reset();
        step(1, 0, 3'b000);
        step(1, 0, 3'b000);
    endtask

    initial begin
        int pref;
        int k;
        bit r;
        bit v;
        logic [2:0] p;
        model_reset();
        reset = 1; valid = 0; pattern = 3'b000;

        // Reset state
        do_reset();
        chk("reset mode", 32'(mode), 0);
        chk("reset locked", 32'(locked), 0);
        chk("reset err_count", 32'(err_count), 0);

        // CALM lock
        feed(C); feed(A); feed(C); feed(A);
        chk("calm locked", 32'(locked), 1);
        chk("calm mode", 32'(mode), 0);
        chk("calm mode_change", 32'(mode_change), 1);
        step(0, 0, A);
        chk("calm mode_change drop", 32'(mode_change), 0);

        // LOCK_COUNT=1 instance locks on the first transition
        do_reset();
        feed(C); feed(A);
        chk("lock1 locked", 32'(locked1), 1);
        chk("lock1 mode_change", 32'(mode_change1), 1);
        feed(L);
        chk("lock1 mode", 32'(mode1), 1);

        // WIND0 lock, continuing agreement gives no pulses
        do_reset();
        feed(C); feed(L); feed(R); feed(A);
        chk("w0 locked", 32'(locked), 1);
        chk("w0 mode", 32'(mode), 1);
        feed(L); feed(R);
        chk("w0 hold mode", 32'(mode), 1);
        chk("w0 hold mode_change", 32'(mode_change), 0);

        // Illegal code while locked WIND0, then relock on CALM
        feed(3'b111);
        chk("illegal err", 32'(err), 1);
        chk("illegal locked", 32'(locked), 0);
        chk("illegal mode held", 32'(mode), 1);
        feed(C); feed(A); feed(C);
        chk("relock pending", 32'(locked), 0);
        feed(A);
        chk("relock locked", 32'(locked), 1);
        chk("relock mode", 32'(mode), 0);

        // Mode switches while locked: CALM -> WIND0 -> WIND1
        feed(L); feed(R);
        chk("switch w0 pending", 32'(mode), 0);
        feed(A);
        chk("switch w0 mode", 32'(mode), 1);
        chk("switch w0 pulse", 32'(mode_change), 1);
        chk("switch locked", 32'(locked), 1);
        feed(R); feed(L); feed(A);
        chk("switch w1 mode", 32'(mode), 2);
        chk("switch w1 pulse", 32'(mode_change), 1);

        // Repeated code is an illegal transition
        do_reset();
        feed(A); feed(A);
        chk("repeat err", 32'(err), 1);
        chk("repeat err_count", 32'(err_count), 32'(ECNT_EN));
        feed(C);
        chk("repeat recover err", 32'(err), 0);

        // Reset mid-lock with valid high, then gap-transparent transition
        feed(A); feed(C); feed(A);
        step(1, 1, C);
        chk("midreset mode", 32'(mode), 0);
        chk("midreset locked", 32'(locked), 0);
        chk("midreset err", 32'(err), 0);
        feed(L);
        for (int i = 0; i < 5; i++) step(0, 0, L);
        feed(R);
        chk("gap err", 32'(err), 0);
        chk("gap locked", 32'(locked), 0);

        // Randomized traffic against the model
        pref = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) pref = int'($urandom_range(0, 2));
            k = int'($urandom_range(0, 9));
            if (k < 7) p = follow(m_have, m_prev, pref);
            else if (k == 7) begin
                case ($urandom_range(0, 3))
                    0: p = C;
                    1: p = A;
                    2: p = L;
                    default: p = R;
                endcase
            end else p = 3'($urandom);
            step(r, v, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
